fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch stage feeding the decoder: owns the PC, issues word requests to instruction memory,
//  buffers returned instructions with their PC, and presents opcode/f3/f7 fields downstream.
//  Handles decoder backpressure and branch/jump redirects (from doBranch/doJump resolution).
// PARAMETERS
//  XLEN      32            data/address width
//  RESET_PC  32'h0000_0000 PC after reset; bits [1:0] must be 0
//  DEPTH     2             instruction buffer entries (>=2, power of 2)
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     asynchronous active-low reset
//  imemReq      out  1     request valid
//  imemAddr     out  XLEN  request word address
//  imemReady    in   1     memory accepts request this cycle
//  imemRvalid   in   1     read data valid (one response per accepted request, in order, latency >=1)
//  imemRdata    in   32    instruction word
//  redirect     in   1     taken branch/jump: restart fetch
//  redirectPc   in   XLEN  target PC; bits [1:0] ignored (forced 0)
//  idValid      out  1     buffer head valid
//  idReady      in   1     decoder consumes head
//  idInstr      out  32    head instruction
//  idPc         out  XLEN  head PC
//  idOpcode     out  7     idInstr[6:0]
//  idF3         out  3     idInstr[14:12]
//  idF7         out  7     idInstr[31:25]
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state REQ, buffer empty; imemReq=0, idValid=0, all id* data outputs 0.
//  - FSM REQ/WAIT/DROP, at most one outstanding request.
//    REQ : imemReq=1 if count<DEPTH and !redirect; imemAddr=pc. On imemReq&imemReady: reqPc<=pc,
//          pc<=pc+4 (mod 2^XLEN), ->WAIT.
//    WAIT: on imemRvalid push {reqPc,imemRdata}; same cycle imemReq may assert (back-to-back)
//          if count+1<DEPTH and !redirect; accepted -> stay WAIT, else ->REQ.
//    DROP: wait for imemRvalid, discard data, ->REQ. imemReq=0.
//  - Pop on idValid&idReady; push and pop in the same cycle allowed (count unchanged).
//  - Overflow impossible: space reserved at issue. No pop credit counted at issue.
//  - Redirect (highest priority): buffer flushed, pop ignored, pc<={redirectPc[XLEN-1:2],2'b00},
//    no request that cycle. WAIT without rvalid ->DROP; WAIT with rvalid -> data discarded, ->REQ;
//    REQ/DROP keep state (DROP still owes its response). idValid=0 the following cycle.
//  - Latency: accepted request to idValid = memory latency + 1 cycle (registered buffer).
//  - id* outputs are driven from buffer head, stable while idValid&!idReady.
//  - Async reset mid-transaction drops everything; memory is reset alongside.
// CONFIGURATION
//  FETCH_PERF_EN defined: extra outputs perfFetched[31:0] (instructions popped) and
//    perfStall[31:0] (cycles idValid&!idReady). Both wrap, reset 0, unaffected by redirect.
//  Not defined: ports and counters absent; otherwise identical behaviour.
// STRUCTURE
//  fetch_pkg: XLEN default, opcode constants (OP_R 7'b0110011, OP_I 7'b0010011, OP_L 7'b0000011,
//    OP_S 7'b0100011, OP_B 7'b1100011, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR),
//    fetch_state_t enum {REQ,WAIT,DROP}, fetch_entry_t struct {pc, instr}.
//  Sub-module fetch_fifo: DEPTH-entry fetch_entry_t FIFO with push/pop/flush and count.
// TESTING
//  1 rst_n=0 mid-request -> imemReq=0, idValid=0; release -> first imemAddr=0x0000_0000.
//  2 1-cycle memory, idReady=1, words 0x00000033,0x00100093,0x00002083 -> idPc 0,4,8;
//    idOpcode 0110011,0010011,0000011; no gaps after fill.
//  3 idReady=0: after 2 entries imemReq stays 0; idReady=1 -> fetch resumes, no loss/duplication.
//  4 3-cycle latency, redirect to 0x104 in WAIT -> response dropped, next imemAddr=0x104, idPc 0x104.
//  5 redirect same cycle as imemRvalid and pop -> idValid=0 next cycle, data discarded, next addr target.
//  6 RESET_PC=0xFFFF_FFFC -> second imemAddr=0x0; FETCH_PERF_EN: 5 pops, 3 stalls -> 5/3.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of fetched {pc, instr} pairs. Flush wins over push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic           pop,
  input  logic           flush,
  input  fetch_entry_t   din,
  output fetch_entry_t   head,
  output logic [CW-1:0]  count
);

  fetch_entry_t          mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);
  assign head    = mem[rd_ptr];

  // entry storage; cleared on reset so the head reads zero while empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // pointers and occupancy; power-of-2 depth lets pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one word request at a time,
// buffers responses with their PC and presents decoded fields to the decoder.
// Optional FETCH_PERF_EN adds perfFetched/perfStall counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imemReq,
  output logic [XLEN-1:0]  imemAddr,
  input  logic             imemReady,
  input  logic             imemRvalid,
  input  logic [31:0]      imemRdata,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirectPc,
  output logic             idValid,
  input  logic             idReady,
  output logic [31:0]      idInstr,
  output logic [XLEN-1:0]  idPc,
  output logic [6:0]       idOpcode,
  output logic [2:0]       idF3,
  output logic [6:0]       idF7
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perfFetched,
  output logic [31:0]      perfStall
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    state;
  logic [XLEN-1:0] pc, req_pc;
  logic            run;
  logic [CW-1:0]   count;
  logic            room_req, room_b2b, issue, push, pop;
  fetch_entry_t    push_ent, head;
  logic            unused_bits;

  // low target bits are forced to zero, never looked at
  assign unused_bits = ^redirectPc[1:0];

  // slot availability: one slot for a fresh request, two when the
  // outstanding response is landing in the same cycle
  always_comb begin
    room_req = count < CW'(DEPTH);
    room_b2b = (count + CW'(1)) < CW'(DEPTH);
  end

  // request generation; run holds imemReq low until the first edge after reset
  always_comb begin
    imemReq = 1'b0;
    if (run && !redirect) begin
      case (state)
        REQ:     imemReq = room_req;
        WAIT:    imemReq = imemRvalid && room_b2b;
        default: imemReq = 1'b0;
      endcase
    end
  end

  assign imemAddr = pc;
  assign issue    = imemReq && imemReady;
  assign push     = (state == WAIT) && imemRvalid && !redirect;
  assign pop      = idValid && idReady && !redirect;
  assign push_ent = '{pc: req_pc, instr: imemRdata};
  assign idValid  = (count != '0);

  // PC, request bookkeeping and REQ/WAIT/DROP sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= REQ;
      pc     <= {RESET_PC[XLEN-1:2], 2'b00};
      req_pc <= '0;
      run    <= 1'b0;
    end else begin
      run <= 1'b1;
      if (issue) begin
        req_pc <= pc;
        pc     <= pc + XLEN'(4);
      end
      if (redirect) pc <= {redirectPc[XLEN-1:2], 2'b00};
      case (state)
        REQ:  if (issue) state <= WAIT;
        WAIT: begin
          if (redirect)        state <= imemRvalid ? REQ : DROP;
          else if (imemRvalid) state <= issue ? WAIT : REQ;
        end
        // the abandoned request still owes its response
        DROP: if (imemRvalid) state <= REQ;
        default: state <= REQ;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (push_ent),
    .head  (head),
    .count (count)
  );

  assign idInstr  = head.instr;
  assign idPc     = head.pc;
  assign idOpcode = head.instr[6:0];
  assign idF3     = head.instr[14:12];
  assign idF7     = head.instr[31:25];

`ifdef FETCH_PERF_EN
  // pop and stall counters, wrap freely, untouched by redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perfFetched <= '0;
      perfStall   <= '0;
    end else begin
      if (pop)                perfFetched <= perfFetched + 32'd1;
      if (idValid && !idReady) perfStall  <= perfStall + 32'd1;
    end
  end
`endif

endmodule
